// File: rtl/tmr_pkg.sv
// Shared types and default sizing for the loadable down-counter timer.
package tmr_pkg;

  localparam int DW_DEF      = 4;
  localparam int MAXLOAD_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tmr_state_e;

  // Architectural view of the timer at the default width.
  typedef struct packed {
    logic [DW_DEF-1:0] count;
    logic [DW_DEF-1:0] reload;
    logic              periodic;
    logic              udf;
    logic              done;
  } tmr_t;

endpackage

// File: rtl/dwn_cntr_ld.sv
// DW-bit down-counter with clear, synchronous load and decrement enable.
// Priority: clear > load > decrement. Decrement stops at zero.
module dwn_cntr_ld #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [DW-1:0] load_val_i,
  input  logic          dec_i,
  output logic [DW-1:0] count_o,
  output logic          zero_o
);

  logic [DW-1:0] count_q, count_d;

  // Next count: clear wins over load, load wins over decrement.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - DW'(1);
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/tmr_dwn_mod_n_udf.sv
// Loadable mod-(L+1) down-counter timer, one-shot or periodic, with a
// registered underflow pulse and done level.
module tmr_dwn_mod_n_udf
  import tmr_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int MAXLOAD = MAXLOAD_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic          i_periodic,
  input  logic [DW-1:0] i_load_val,
  input  logic          i_enb,
  output logic [DW-1:0] o_count,
  output logic          o_busy,
  output logic          o_udf,
  output logic          o_done
);

  localparam logic [DW-1:0] MAXLOAD_W = DW'(MAXLOAD);

  tmr_state_e    state_q, state_d;
  logic [DW-1:0] reload_q, reload_d;
  logic          periodic_q, periodic_d;
  logic          udf_q, udf_d;
  logic          busy_q, done_q;

  logic [DW-1:0] load_sat;
  logic          cnt_clr, cnt_load, cnt_dec, cnt_zero;
  logic [DW-1:0] cnt_load_val;

  assign load_sat = (i_load_val > MAXLOAD_W) ? MAXLOAD_W : i_load_val;

  // Next state, reload latch and counter controls; stop > start > enb.
  always_comb begin
    state_d      = state_q;
    reload_d     = reload_q;
    periodic_d   = periodic_q;
    udf_d        = 1'b0;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = load_sat;
    cnt_dec      = 1'b0;
    if (i_stop) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end else if (i_start) begin
      // A restart never produces an underflow, even at count zero.
      state_d    = RUN;
      reload_d   = load_sat;
      periodic_d = i_periodic;
      cnt_load   = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (i_enb) begin
            if (cnt_zero) begin
              udf_d = 1'b1;
              if (periodic_q) begin
                cnt_load     = 1'b1;
                cnt_load_val = reload_q;
              end else begin
                state_d = DONE;
              end
            end else begin
              cnt_dec = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State, latched load/mode and registered output flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      reload_q   <= '0;
      periodic_q <= 1'b0;
      udf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
      udf_q      <= udf_d;
      busy_q     <= (state_d == RUN);
      done_q     <= (state_d == DONE);
    end
  end

  dwn_cntr_ld #(.DW(DW)) u_cntr (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .count_o    (o_count),
    .zero_o     (cnt_zero)
  );

  assign o_busy = busy_q;
  assign o_udf  = udf_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_tmr_dwn_mod_n_udf.sv
// Self-checking bench: behavioural timer model compared every cycle,
// directed scenarios with literal pins, then randomized strobes.
module tb_tmr_dwn_mod_n_udf;
  import tmr_pkg::*;

  localparam int DW      = 4;
  localparam int MAXLOAD = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic          i_stop = 1'b0;
  logic          i_periodic = 1'b0;
  logic [DW-1:0] i_load_val = '0;
  logic          i_enb = 1'b0;
  logic [DW-1:0] o_count;
  logic          o_busy;
  logic          o_udf;
  logic          o_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: architectural timer contents plus a "running" flag.
  tmr_t m;
  bit   m_run;

  tmr_dwn_mod_n_udf #(.DW(DW), .MAXLOAD(MAXLOAD)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_periodic (i_periodic),
    .i_load_val (i_load_val),
    .i_enb      (i_enb),
    .o_count    (o_count),
    .o_busy     (o_busy),
    .o_udf      (o_udf),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m     = '0;
    m_run = 1'b0;
  endtask

  // One clock of the timer as described behaviourally.
  task automatic model_step();
    int l;
    m.udf = 1'b0;
    if (i_stop) begin
      m_run   = 1'b0;
      m.done  = 1'b0;
      m.count = '0;
    end else if (i_start) begin
      l          = (int'(i_load_val) > MAXLOAD) ? MAXLOAD : int'(i_load_val);
      m.reload   = 4'(l);
      m.periodic = i_periodic;
      m.count    = 4'(l);
      m_run      = 1'b1;
      m.done     = 1'b0;
    end else if (m_run && i_enb) begin
      if (m.count == 0) begin
        m.udf = 1'b1;
        if (m.periodic) m.count = m.reload;
        else begin
          m_run  = 1'b0;
          m.done = 1'b1;
        end
      end else begin
        m.count = m.count - 4'd1;
      end
    end
  endtask

  task automatic drive(input logic s, input logic p, input logic per,
                       input logic e, input logic [DW-1:0] l);
    i_start    = s;
    i_stop     = p;
    i_periodic = per;
    i_enb      = e;
    i_load_val = l;
  endtask

  // Advance one clock and compare all outputs against the model.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk("count", 32'(o_count), 32'(m.count));
    chk("busy",  32'(o_busy),  32'(m_run));
    chk("udf",   32'(o_udf),   32'(m.udf));
    chk("done",  32'(o_done),  32'(m.done));
    $display("cyc %0d start=%0b stop=%0b per=%0b enb=%0b ld=%0d -> cnt=%0d busy=%0b udf=%0b done=%0b",
             cyc, i_start, i_stop, i_periodic, i_enb, i_load_val, o_count, o_busy, o_udf, o_done);
  endtask

  initial begin
    model_reset();
    // Reset state
    #12;
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_busy",  32'(o_busy),  32'd0);
    chk("rst_udf",   32'(o_udf),   32'd0);
    chk("rst_done",  32'(o_done),  32'd0);
    rst = 1'b0;

    // One-shot L=3, enb continuously high
    drive(1, 0, 0, 1, 4'd3); step();
    chk("os_load", 32'(o_count), 32'd3);
    drive(0, 0, 0, 1, 4'd3);
    step(); chk("os_c2", 32'(o_count), 32'd2);
    step(); chk("os_c1", 32'(o_count), 32'd1);
    step(); chk("os_c0", 32'(o_count), 32'd0);
    chk("os_no_udf_yet", 32'(o_udf), 32'd0);
    step();
    chk("os_udf",  32'(o_udf),  32'd1);
    chk("os_done", 32'(o_done), 32'd1);
    chk("os_busy", 32'(o_busy), 32'd0);
    for (int i = 0; i < 3; i++) step();
    chk("os_done_hold", 32'(o_done), 32'd1);
    chk("os_udf_clr",   32'(o_udf),  32'd0);
    drive(0, 1, 0, 1, 4'd3); step();
    chk("os_stop_done", 32'(o_done), 32'd0);

    // Periodic L=2, enb toggling
    drive(1, 0, 1, 0, 4'd2); step();
    for (int i = 0; i < 14; i++) begin
      drive(0, 0, 1, (i % 2 == 0), 4'd2);
      step();
    end
    chk("per_busy", 32'(o_busy), 32'd1);

    // Saturated load 15 -> 8, then change load value mid-run
    drive(1, 0, 1, 1, 4'd15); step();
    chk("sat_load", 32'(o_count), 32'd8);
    drive(0, 0, 1, 1, 4'd15);
    for (int i = 0; i < 5; i++) step();
    drive(0, 0, 0, 1, 4'd1);
    for (int i = 0; i < 14; i++) step();

    // Restart at count 0 with enb: no udf, new load
    drive(1, 0, 0, 1, 4'd1); step();
    drive(0, 0, 0, 1, 4'd1); step();
    chk("rs_at0", 32'(o_count), 32'd0);
    drive(1, 0, 0, 1, 4'd5); step();
    chk("rs_udf",   32'(o_udf),   32'd0);
    chk("rs_count", 32'(o_count), 32'd5);
    drive(1, 1, 0, 1, 4'd5); step();
    chk("ss_count", 32'(o_count), 32'd0);
    chk("ss_busy",  32'(o_busy),  32'd0);

    // Periodic L=0: udf every enabled cycle, then stop
    drive(1, 0, 1, 1, 4'd0); step();
    drive(0, 0, 1, 1, 4'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("l0_udf", 32'(o_udf), 32'd1);
    end
    drive(0, 1, 1, 1, 4'd0); step();
    chk("l0_stop_udf", 32'(o_udf), 32'd0);

    // Async reset at count 4
    drive(1, 0, 1, 1, 4'd6); step();
    drive(0, 0, 1, 1, 4'd6); step(); step();
    chk("ar_pre", 32'(o_count), 32'd4);
    drive(0, 0, 1, 0, 4'd6);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("ar_count", 32'(o_count), 32'd0);
    chk("ar_busy",  32'(o_busy),  32'd0);
    chk("ar_udf",   32'(o_udf),   32'd0);
    chk("ar_done",  32'(o_done),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 1, 1, 4'd6);
    for (int i = 0; i < 4; i++) step();
    chk("ar_idle_cnt", 32'(o_count), 32'd0);

    // Randomized strobes
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0),
            1'($urandom), 1'($urandom), 4'($urandom));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmr_dwn_mod_n_udf.md
Name: tmr_dwn_mod_n_udf

Overview:
- Loadable mod-(L+1) down-counter timer with an underflow flag. It is the count-down counterpart of the team's mod-n up-counter with overflow.
- It is started by a single-cycle start strobe and counts on `i_enb` ticks, either one-shot or periodic.
- Used by control blocks that need a programmable delay or period, driven by the same enable/tick sources that feed the up-counters.

Parameters:
- DW, 4, width of the count and load value.
- MAXLOAD, 8, largest legal load value. Loads above it are saturated to MAXLOAD.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- i_start  input  1  single-cycle strobe: latch `i_load_val` and begin counting
- i_stop  input  1  single-cycle strobe: abort to IDLE
- i_periodic  input  1  sampled on `i_start`; 1 = reload on underflow, 0 = one-shot
- i_load_val  input  DW  initial/reload count L, sampled on `i_start`
- i_enb  input  1  count tick qualifier
- o_count  output  DW  current count value
- o_busy  output  1  high in RUN
- o_udf  output  1  one-cycle pulse on underflow
- o_done  output  1  level, high in DONE (one-shot finished)

Behaviour:
- Reset (async): state=IDLE, `o_count`=0, `o_busy`=0, `o_udf`=0, `o_done`=0, latched reload=0, latched mode=0.
- All outputs are registered. No combinational path from inputs to outputs.
- Load rule: L = min(`i_load_val`, MAXLOAD). L is stored in a reload register together with `i_periodic`. Later changes on `i_load_val`/`i_periodic` are ignored until the next `i_start`.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `i_start` at edge k → after edge k: state=RUN, `o_count`=L, `o_busy`=1.
  - `i_enb` alone has no effect.
- RUN, on `i_enb`=1:
  - If count>0: count <= count−1.
  - If count==0: `o_udf`=1 for exactly the following cycle.
    - Periodic: count <= reload, stay in RUN.
    - One-shot: go to DONE, count stays 0, `o_busy`=0, `o_done`=1.
- RUN, on `i_enb`=0: count holds.
- Period: L+1 enabled ticks per underflow. L=0 gives an underflow on every enabled tick.
- DONE:
  - `o_done` holds until `i_start` (→ RUN with new load, `o_done`=0) or `i_stop` (→ IDLE).
  - `i_enb` is ignored.
- `i_start` during RUN: restart with the new L and mode. No `o_udf` is generated, even if count==0 and `i_enb`=1 in that same cycle.
- `i_stop` in any state: → IDLE, `o_count`=0, `o_busy`=0, `o_done`=0, no `o_udf`.
- Priority when strobes coincide: `i_stop` > `i_start` > `i_enb`.
- `o_udf` is cleared on every cycle in which the underflow condition is not met. It never stays high for 2 cycles, except in periodic mode with L=0 and `i_enb` continuously high, where it is legitimately high every cycle.
- Reset asserted mid-count: immediate return to reset values. No pending udf/done survives.

Decomposition:
- Package `tmr_pkg` holds:
  - state enum `tmr_state_e` {IDLE, RUN, DONE};
  - struct `tmr_t` {count, reload, periodic, udf, done};
  - default DW/MAXLOAD constants.
- One sub-module, `dwn_cntr_ld`, is natural: a DW-bit down-counter with synchronous load, clear, decrement-enable and a zero output.
- The FSM, saturation and flag registers stay in the top module.

Test Plan:
- Reset, then `i_start` with L=3, one-shot, `i_enb`=1 continuously → `o_count` sequence 3,2,1,0. `o_udf` pulses one cycle on the 4th tick edge. `o_done`=1 and `o_busy`=0 from that edge on, and `o_count` holds 0.
- Periodic, L=2, `i_enb` toggling 1,0,1,0… → count changes only on enabled cycles (2,2,1,1,0,0,2…). `o_udf` fires once every 3 enabled ticks, and `o_busy` stays 1.
- `i_load_val`=15 with MAXLOAD=8 → loads 8. Underflow after 9 enabled ticks. Changing `i_load_val` to 1 mid-run does not alter the reload in periodic mode (next period is again 8..0).
- RUN at count=0 with `i_enb`=1 and `i_start` (L=5) in the same cycle → no `o_udf`, `o_count`=5 next cycle. `i_start`+`i_stop` together → IDLE, `o_count`=0.
- Periodic, L=0, `i_enb`=1 → `o_udf`=1 every cycle and `o_count`=0. `i_stop` → `o_udf`=0 on the next cycle.
- Assert `rst` asynchronously at count=4 (between clock edges) → all outputs 0 immediately. After release, `i_enb` alone causes no counting until `i_start`.
